arcade_input_map: RTL and testbench

Parametrised player-input front end for arcade cores, sitting between `hps_io` and the game core's input-port assembly. Merges PS/2 keyboard events and MiSTer joystick words for 1–4 players and applies screen-rotation remapping and opposing-direction cleaning. It also generates per-button autofire and fixed-length coin pulses. All outputs are registered and active-high; the core inverts them as its ports require.

---
 rtl/arcade_input_map.sv | 192 +++++++++++++++++++
 tb/tb_arcade_input_map.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_map.sv
// Player-input front end: merges PS/2 keys with MiSTer joystick words, then applies
// rotation, opposing-direction cleaning, per-button autofire and stretched coin pulses.
module arcade_input_map #(
    parameter int PLAYERS    = 2,
    parameter int BUTTONS    = 4,
    parameter int COIN_TICKS = 3,
    parameter int AF_DIV     = 2,
    parameter int SOCD       = 1
) (
    input  logic                       clk_sys,
    input  logic                       RESET,
    input  logic                       tick,
    input  logic [10:0]                ps2_key,
    input  logic [16*PLAYERS-1:0]      joystick,
    input  logic [1:0]                 rotate,
    input  logic [PLAYERS*BUTTONS-1:0] autofire_en,
    output logic [4*PLAYERS-1:0]       out_dir,
    output logic [BUTTONS*PLAYERS-1:0] out_btn,
    output logic [PLAYERS-1:0]         out_start,
    output logic [PLAYERS-1:0]         out_coin
);

    localparam int KP = (PLAYERS < 2) ? PLAYERS : 2;
    localparam int KB = (BUTTONS < 4) ? BUTTONS : 4;

    // Keyboard map indexed [player][bit]; direction bit order is R, L, D, U.
    localparam logic [7:0] DIR_KEY [2][4] = '{'{8'h74, 8'h6B, 8'h72, 8'h75},
                                             '{8'h34, 8'h23, 8'h2B, 8'h2D}};
    localparam logic [7:0] BTN_KEY [2][4] = '{'{8'h14, 8'h11, 8'h29, 8'h12},
                                             '{8'h1C, 8'h1B, 8'h15, 8'h1D}};
    localparam logic [7:0] START_KEY [4]  = '{8'h16, 8'h1E, 8'h26, 8'h25};
    localparam logic [7:0] COIN_KEY [4]   = '{8'h2E, 8'h36, 8'h3D, 8'h3E};

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} coin_state_t;

    logic                            old_tog;
    logic                            key_event;
    logic [7:0]                      code;
    logic [PLAYERS-1:0][3:0]         kdir;
    logic [PLAYERS-1:0][BUTTONS-1:0] kbtn;
    logic [PLAYERS-1:0]              kstart;
    logic [PLAYERS-1:0]              kcoin;
    logic [3:0]                      af_div;
    logic                            af_phase;
    logic [3:0]                      rdir;
    logic [BUTTONS-1:0]              rbtn;
    logic [4*PLAYERS-1:0]            dir_nxt;
    logic [BUTTONS*PLAYERS-1:0]      btn_nxt;
    logic [PLAYERS-1:0]              start_nxt;
    logic [PLAYERS-1:0]              raw_coin;
    logic [PLAYERS-1:0]              coin_d;
    logic [PLAYERS-1:0]              coin_rise;
    coin_state_t                     cst     [PLAYERS];
    coin_state_t                     cst_nxt [PLAYERS];
    logic [3:0]                      ccnt     [PLAYERS];
    logic [3:0]                      ccnt_nxt [PLAYERS];
    logic                            unused_in;

    assign key_event = (ps2_key[10] != old_tog);
    assign code      = ps2_key[7:0];
    // Reserved joystick bits and the E0 flag carry no function here.
    assign unused_in = ^{joystick, ps2_key[8]};

    function automatic logic [3:0] rotate_dir(input logic [3:0] d, input logic [1:0] r);
        case (r)
            2'd1:    return {d[1], d[0], d[2], d[3]};
            2'd2:    return {d[2], d[3], d[0], d[1]};
            2'd3:    return {d[0], d[1], d[3], d[2]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk_sys) begin
        old_tog <= ps2_key[10];
        if (RESET) begin
            kdir   <= '0;
            kbtn   <= '0;
            kstart <= '0;
            kcoin  <= '0;
        end else if (key_event) begin
            for (int unsigned p = 0; p < KP; p++) begin
                for (int unsigned d = 0; d < 4; d++)
                    if (code == DIR_KEY[p][d]) kdir[p][d] <= ps2_key[9];
                for (int unsigned b = 0; b < KB; b++)
                    if (code == BTN_KEY[p][b]) kbtn[p][b] <= ps2_key[9];
            end
            for (int unsigned p = 0; p < PLAYERS; p++) begin
                if (code == START_KEY[p] || (p == 0 && code == 8'h05) || (p == 1 && code == 8'h06))
                    kstart[p] <= ps2_key[9];
                if (code == COIN_KEY[p]) kcoin[p] <= ps2_key[9];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            af_div   <= '0;
            af_phase <= 1'b1;
        end else if (tick) begin
            if (af_div == 4'(AF_DIV - 1)) begin
                af_div   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_div <= af_div + 4'd1;
            end
        end
    end

    always_comb begin
        dir_nxt   = '0;
        btn_nxt   = '0;
        start_nxt = '0;
        raw_coin  = '0;
        rdir      = '0;
        rbtn      = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            rdir = rotate_dir(joystick[16*p +: 4] | kdir[p], rotate);
            if (SOCD != 0) begin
                if (rdir[3] && rdir[2]) rdir[3:2] = '0;
                if (rdir[1] && rdir[0]) rdir[1:0] = '0;
            end
            dir_nxt[4*p +: 4] = rdir;
            rbtn = joystick[16*p+4 +: BUTTONS] | kbtn[p];
            for (int unsigned b = 0; b < BUTTONS; b++)
                btn_nxt[p*BUTTONS+b] = autofire_en[p*BUTTONS+b] ? (rbtn[b] & af_phase) : rbtn[b];
            start_nxt[p] = joystick[16*p+12] | kstart[p];
            raw_coin[p]  = joystick[16*p+13] | kcoin[p];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            out_dir   <= '0;
            out_btn   <= '0;
            out_start <= '0;
            out_coin  <= '0;
            coin_d    <= '0;
            coin_rise <= '0;
        end else begin
            out_dir   <= dir_nxt;
            out_btn   <= btn_nxt;
            out_start <= start_nxt;
            coin_d    <= raw_coin;
            coin_rise <= raw_coin & ~coin_d;
            // Registered from the next state so out_coin tracks PULSE with no extra delay.
            for (int unsigned p = 0; p < PLAYERS; p++)
                out_coin[p] <= (cst_nxt[p] == C_PULSE);
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            if (RESET) begin
                cst[p]  <= C_IDLE;
                ccnt[p] <= '0;
            end else begin
                cst[p]  <= cst_nxt[p];
                ccnt[p] <= ccnt_nxt[p];
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            cst_nxt[p]  = cst[p];
            ccnt_nxt[p] = ccnt[p];
            case (cst[p])
                C_IDLE: begin
                    if (coin_rise[p]) begin
                        cst_nxt[p]  = C_PULSE;
                        ccnt_nxt[p] = 4'(COIN_TICKS);
                    end
                end
                C_PULSE: begin
                    if (tick) begin
                        if (ccnt[p] <= 4'd1) begin
                            ccnt_nxt[p] = '0;
                            cst_nxt[p]  = raw_coin[p] ? C_WAIT : C_IDLE;
                        end else begin
                            ccnt_nxt[p] = ccnt[p] - 4'd1;
                        end
                    end
                end
                C_WAIT: begin
                    if (!raw_coin[p]) cst_nxt[p] = C_IDLE;
                end
                default: cst_nxt[p] = C_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arcade_input_map.sv
// Scoreboard bench for arcade_input_map: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_arcade_input_map;

    localparam int ID_DIR   = 0;
    localparam int ID_BTN   = 1;
    localparam int ID_START = 2;
    localparam int ID_COIN  = 3;
    localparam int ID_DIR0  = 4;
    localparam int ID_ALT0  = 5;

    logic        clk_sys     = 1'b0;
    logic        RESET       = 1'b1;
    logic        tick        = 1'b0;
    logic [10:0] ps2_key     = '0;
    logic [31:0] joystick    = '1;
    logic [1:0]  rotate      = 2'd0;
    logic [7:0]  autofire_en = '0;

    logic [7:0] out_dir, out_btn, dir0, btn0;
    logic [1:0] out_start, out_coin, start0, coin0;

    arcade_input_map #(.PLAYERS(2), .BUTTONS(4), .COIN_TICKS(3), .AF_DIV(2), .SOCD(1)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .tick(tick), .ps2_key(ps2_key),
        .joystick(joystick), .rotate(rotate), .autofire_en(autofire_en),
        .out_dir(out_dir), .out_btn(out_btn), .out_start(out_start), .out_coin(out_coin)
    );

    arcade_input_map #(.PLAYERS(2), .BUTTONS(4), .COIN_TICKS(3), .AF_DIV(2), .SOCD(0)) dut0 (
        .clk_sys(clk_sys), .RESET(RESET), .tick(tick), .ps2_key(ps2_key),
        .joystick(joystick), .rotate(rotate), .autofire_en(autofire_en),
        .out_dir(dir0), .out_btn(btn0), .out_start(start0), .out_coin(coin0)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] got;

    function automatic logic [31:0] field(input int id);
        case (id)
            ID_DIR:   return {24'b0, out_dir};
            ID_BTN:   return {24'b0, out_btn};
            ID_START: return {30'b0, out_start};
            ID_COIN:  return {30'b0, out_coin};
            ID_DIR0:  return {24'b0, dir0};
            default:  return {20'b0, btn0, start0, coin0};
        endcase
    endfunction

    always @(negedge clk_sys) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                got = field(sbq[i].id);
                n_checks++;
                if (sbq[i].due == cyc && got === sbq[i].val)
                    n_pass++;
                else
                    $display("FAIL %s (cycle %0d, due %0d): got %h expected %h",
                             sbq[i].name, cyc, sbq[i].due, got, sbq[i].val);
                sbq.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic push_exp(input int dly, input int id, input logic [31:0] val, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.id   = id;
        e.val  = val;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic key(input logic pressed, input logic [8:0] kc);
        ps2_key = {~ps2_key[10], pressed, kc};
    endtask

    task automatic do_reset;
        RESET = 1'b1;
        step(2);
        RESET = 1'b0;
    endtask

    int   div_m;
    logic ph, ph_prev;

    initial begin
        // Reset with all joystick bits held, then release.
        step(3);
        n_checks++;
        if (out_dir === 8'h00) n_pass++;
        else $display("FAIL rst_dir_direct: got %h expected 00", out_dir);
        push_exp(0, ID_DIR,   32'h0, "rst_dir");
        push_exp(0, ID_BTN,   32'h0, "rst_btn");
        push_exp(0, ID_START, 32'h0, "rst_start");
        push_exp(0, ID_COIN,  32'h0, "rst_coin");
        push_exp(0, ID_ALT0,  32'h0, "rst_alt0");
        RESET = 1'b0;
        push_exp(1, ID_BTN,   32'hFF,  "rel_btn");
        push_exp(1, ID_START, 32'h3,   "rel_start");
        push_exp(1, ID_DIR,   32'h00,  "rel_dir_socd");
        push_exp(1, ID_DIR0,  32'hFF,  "rel_dir_raw");
        push_exp(1, ID_ALT0,  32'hFFC, "rel_alt0");
        push_exp(1, ID_COIN,  32'h0,   "rel_coin_early");
        push_exp(2, ID_COIN,  32'h3,   "rel_coin_pulse");
        step(1);
        joystick = '0;
        push_exp(1, ID_DIR0, 32'h00, "joy_clear");
        step(3);

        // PS/2 press/release, start alias, P2 key, unmapped code, joystick overlap, coin key.
        do_reset;
        key(1'b1, 9'h175);
        push_exp(1, ID_DIR, 32'h00, "key_u_lat1");
        push_exp(2, ID_DIR, 32'h08, "key_u_press");
        step(3);
        key(1'b0, 9'h075);
        push_exp(1, ID_DIR, 32'h08, "key_u_hold");
        push_exp(2, ID_DIR, 32'h00, "key_u_release");
        step(3);
        key(1'b1, 9'h005);
        push_exp(2, ID_START, 32'h1, "key_f1_start");
        step(3);
        key(1'b0, 9'h005);
        push_exp(2, ID_START, 32'h0, "key_f1_release");
        step(3);
        key(1'b1, 9'h02D);
        push_exp(2, ID_DIR, 32'h80, "key_p2_u");
        step(3);
        key(1'b1, 9'h0FF);
        push_exp(2, ID_DIR,   32'h80, "key_unmapped_dir");
        push_exp(2, ID_START, 32'h0,  "key_unmapped_start");
        step(3);
        joystick = 32'h0008_0000;
        key(1'b0, 9'h02D);
        push_exp(2, ID_DIR, 32'h80, "key_rel_joy_held");
        step(3);
        joystick = '0;
        push_exp(1, ID_DIR, 32'h00, "joy_p2_release");
        step(3);
        key(1'b1, 9'h02E);
        push_exp(2, ID_COIN, 32'h0, "key_coin_early");
        push_exp(3, ID_COIN, 32'h1, "key_coin_pulse");
        step(4);

        // Rotation and SOCD.
        do_reset;
        rotate = 2'd1; joystick = 32'h2;
        push_exp(1, ID_DIR, 32'h08, "rot1_l_to_u");
        step(2);
        joystick = 32'h8;
        push_exp(1, ID_DIR, 32'h01, "rot1_u_to_r");
        step(2);
        rotate = 2'd2;
        push_exp(1, ID_DIR, 32'h04, "rot2_u_to_d");
        step(2);
        rotate = 2'd3;
        push_exp(1, ID_DIR, 32'h02, "rot3_u_to_l");
        step(2);
        rotate = 2'd0; joystick = 32'hC;
        push_exp(1, ID_DIR,  32'h00, "socd_ud");
        push_exp(1, ID_DIR0, 32'h0C, "nosocd_ud");
        step(2);
        joystick = 32'h3;
        push_exp(1, ID_DIR,  32'h00, "socd_lr");
        push_exp(1, ID_DIR0, 32'h03, "nosocd_lr");
        step(2);
        joystick = 32'h9;
        push_exp(1, ID_DIR,  32'h09, "socd_ur");
        push_exp(1, ID_DIR0, 32'h09, "nosocd_ur");
        step(2);
        n_checks++;
        if (dir0 === 8'h09) n_pass++;
        else $display("FAIL nosocd_ur_direct: got %h expected 09", dir0);
        joystick = '0;

        // Autofire on P1 button 0, button 1 held without autofire.
        do_reset;
        joystick = 32'h30; autofire_en = 8'h01;
        push_exp(1, ID_BTN, 32'h03, "af_start");
        div_m = 0; ph = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(9);
            tick = 1'b1;
            ph_prev = ph;
            div_m++;
            if (div_m == 2) begin
                div_m = 0;
                ph = ~ph;
            end
            push_exp(1, ID_BTN, {30'b0, 1'b1, ph_prev}, "af_before");
            push_exp(2, ID_BTN, {30'b0, 1'b1, ph},      "af_after");
            step(1);
            tick = 1'b0;
        end
        step(3);
        autofire_en = '0;
        push_exp(1, ID_BTN, 32'h03, "af_off");
        step(2);
        n_checks++;
        if (out_btn === 8'h03) n_pass++;
        else $display("FAIL af_off_direct: got %h expected 03", out_btn);

        // Coin: short press, long hold, re-press, reset mid-pulse.
        do_reset;
        joystick = 32'h2000;
        push_exp(1, ID_COIN, 32'h0, "coin_short_lat");
        push_exp(2, ID_COIN, 32'h1, "coin_short_rise");
        step(1);
        joystick = '0;
        for (int k = 1; k <= 3; k++) begin
            step(9);
            tick = 1'b1;
            push_exp(0, ID_COIN, 32'h1, "coin_short_hold");
            push_exp(1, ID_COIN, (k == 3) ? 32'h0 : 32'h1, "coin_short_tick");
            step(1);
            tick = 1'b0;
        end
        step(3);
        joystick = 32'h2000;
        push_exp(2, ID_COIN, 32'h1, "coin_long_rise");
        step(1);
        for (int k = 1; k <= 10; k++) begin
            step(9);
            tick = 1'b1;
            push_exp(1, ID_COIN, (k < 3) ? 32'h1 : 32'h0, "coin_long_tick");
            step(1);
            tick = 1'b0;
        end
        step(5);
        joystick = '0;
        push_exp(1, ID_COIN, 32'h0, "coin_release");
        push_exp(3, ID_COIN, 32'h0, "coin_release_idle");
        step(4);
        joystick = 32'h2000;
        push_exp(2, ID_COIN, 32'h1, "coin_repress");
        step(5);
        RESET = 1'b1;
        push_exp(0, ID_COIN, 32'h1, "coin_pre_reset");
        push_exp(1, ID_COIN, 32'h0, "coin_reset_clear");
        step(1);
        RESET = 1'b0;
        push_exp(1, ID_COIN, 32'h0,   "coin_post_reset_edge");
        push_exp(2, ID_COIN, 32'h1,   "coin_post_reset_pulse");
        push_exp(2, ID_ALT0, 32'h001, "coin_post_reset_alt0");
        step(3);
        joystick = '0;

        for (int i = 0; i < 20 && sbq.size() != 0; i++) step(1);
        while (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL %s: got no sample expected %h by cycle %0d", sbq[0].name, sbq[0].val, sbq[0].due);
            void'(sbq.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
